mutex_arbiter_n: RTL and testbench

- Synchronous, parametrised N-way mutual-exclusion arbiter.
- Successor to the fixed 4-input pairwise-mutex arbiter. Adds the following:
  - clocked request/grant handshake;
  - selectable fixed or round-robin priority;
  - break-before-make hand-over;
  - optional maximum-hold timeout that forcibly revokes a grant.
- Sits between N requesting agents and one shared resource. At most one grant is active in any cycle.

---
 rtl/mutex_arbiter_n.sv | 87 ++++++++
 tb/tb_mutex_arbiter_n.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mutex_arbiter_n.sv
// mutex_arbiter_n: N-way registered mutex arbiter, fixed or round-robin priority, optional hold timeout
module mutex_arbiter_n #(
  parameter int N = 4,
  parameter int RR_MODE = 1,
  parameter int MAX_HOLD = 0,
  localparam int IDW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           hold_expired
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [N-1:0] gnt_q, gnt_d, block_q, block_d, elig;
  logic [IDW-1:0] id_q, id_d, rr_q, rr_d, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, exp_q, exp_d;
  assign elig = req & ~block_q;
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--) if (elig[i]) win = IDW'(i);
    if (RR_MODE != 0)
      for (int i = N - 1; i >= 0; i--) if (elig[i] && IDW'(i) >= rr_q) win = IDW'(i);
  end
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    id_d = id_q;
    busy_d = busy_q;
    exp_d = 1'b0;
    rr_d = rr_q;
    cnt_d = cnt_q;
    block_d = block_q & req;
    if (state_q == IDLE) begin
      if (|elig) begin
        state_d = GRANT;
        gnt_d = N'(1) << win;
        id_d = win;
        busy_d = 1'b1;
        cnt_d = CW'(1);
        if (RR_MODE != 0) rr_d = (win == IDW'(N - 1)) ? '0 : win + 1'b1;
      end
    end else if (!req[id_q] || (MAX_HOLD != 0 && cnt_q == CW'(MAX_HOLD))) begin
      state_d = IDLE;
      gnt_d = '0;
      id_d = '0;
      busy_d = 1'b0;
      cnt_d = '0;
      if (req[id_q]) begin
        block_d[id_q] = 1'b1;
        exp_d = 1'b1;
      end
    end else if (MAX_HOLD != 0) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      id_q <= '0;
      busy_q <= 1'b0;
      exp_q <= 1'b0;
      rr_q <= '0;
      cnt_q <= '0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      id_q <= id_d;
      busy_q <= busy_d;
      exp_q <= exp_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      block_q <= block_d;
    end
  end
  assign gnt = gnt_q;
  assign gnt_id = id_q;
  assign busy = busy_q;
  assign hold_expired = exp_q;
endmodule

// File: tb/tb_mutex_arbiter_n.sv
// tb_mutex_arbiter_n: scoreboard bench comparing five arbiter builds against a behavioural model
module tb_mutex_arbiter_n;
  localparam int NI = 5;
  localparam int NS [NI] = '{4, 4, 8, 2, 4};
  localparam int RRS [NI] = '{0, 1, 1, 0, 1};
  localparam int MHS [NI] = '{0, 3, 5, 1, 0};
  typedef struct {
    logic [31:0] gnt;
    logic [31:0] id;
    logic busy;
    logic expd;
    logic [31:0] req;
    logic [31:0] mask;
  } exp_t;
  typedef struct {
    int owner;
    int held;
    int ptr;
    logic [31:0] blk;
  } ms_t;
  logic clk, rst_n;
  logic [31:0] req_v [NI];
  logic [31:0] gnt_v [NI];
  logic [31:0] id_v [NI];
  logic busy_v [NI];
  logic exp_v [NI];
  exp_t q [NI][$];
  ms_t ms [NI];
  int n_pass, n_total;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NI; g++) begin : u
    localparam int N = NS[g];
    logic [N-1:0] gt;
    logic [$clog2(N)-1:0] it;
    logic b, x;
    mutex_arbiter_n #(.N(N), .RR_MODE(RRS[g]), .MAX_HOLD(MHS[g])) dut (
      .clk(clk), .rst_n(rst_n), .req(req_v[g][N-1:0]),
      .gnt(gt), .gnt_id(it), .busy(b), .hold_expired(x)
    );
    assign gnt_v[g] = 32'(gt);
    assign id_v[g] = 32'(it);
    assign busy_v[g] = b;
    assign exp_v[g] = x;
  end
  function automatic logic [31:0] nmask(input int g);
    return (32'(1) << NS[g]) - 1;
  endfunction
  function automatic void model_reset();
    for (int g = 0; g < NI; g++) begin
      ms[g].owner = -1;
      ms[g].held = 0;
      ms[g].ptr = 0;
      ms[g].blk = '0;
    end
  endfunction
  function automatic exp_t step(input int g, input logic [31:0] r);
    exp_t e;
    int n, o;
    n = NS[g];
    e.req = r;
    e.expd = 1'b0;
    for (int i = 0; i < n; i++) if (!r[i]) ms[g].blk[i] = 1'b0;
    o = ms[g].owner;
    if (o < 0) begin
      for (int k = 0; k < n; k++) begin
        int j;
        j = ((RRS[g] != 0 ? ms[g].ptr : 0) + k) % n;
        if (o < 0 && r[j] && !ms[g].blk[j]) o = j;
      end
      if (o >= 0) begin
        ms[g].held = 1;
        if (RRS[g] != 0) ms[g].ptr = (o + 1) % n;
      end
    end else if (!r[o]) begin
      o = -1;
    end else if (MHS[g] != 0 && ms[g].held == MHS[g]) begin
      ms[g].blk[o] = 1'b1;
      e.expd = 1'b1;
      o = -1;
    end else if (ms[g].held < MHS[g]) begin
      ms[g].held++;
    end
    ms[g].owner = o;
    e.gnt = (o >= 0) ? 32'(1) << o : '0;
    e.id = (o >= 0) ? 32'(o) : '0;
    e.busy = o >= 0;
    e.mask = r & ~ms[g].blk;
    return e;
  endfunction
  task automatic tick();
    for (int g = 0; g < NI; g++) q[g].push_back(step(g, req_v[g]));
    @(posedge clk);
    #2;
  endtask
  task automatic set_all(input logic [31:0] r, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int g = 0; g < NI; g++) req_v[g] = r & nmask(g);
      tick();
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask
  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s dut%0d got %0h expected %0h at %0t", nm, g, act, want, $time);
  endtask
  initial begin
    exp_t e;
    logic [31:0] lg [NI];
    int wt [NI][32];
    int mx;
    n_pass = 0;
    n_total = 0;
    for (int g = 0; g < NI; g++) begin
      lg[g] = '0;
      for (int i = 0; i < 32; i++) wt[g][i] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      for (int g = 0; g < NI; g++) begin
        if (!rst_n) begin
          chk("rst_gnt", g, gnt_v[g], '0);
          chk("rst_id", g, id_v[g], '0);
          chk("rst_busy", g, 32'(busy_v[g]), '0);
          chk("rst_exp", g, 32'(exp_v[g]), '0);
          q[g].delete();
          lg[g] = '0;
          for (int i = 0; i < 32; i++) wt[g][i] = 0;
        end else if (q[g].size() != 0) begin
          e = q[g].pop_front();
          chk("gnt", g, gnt_v[g], e.gnt);
          chk("gnt_id", g, id_v[g], e.id);
          chk("busy", g, 32'(busy_v[g]), 32'(e.busy));
          chk("hold_expired", g, 32'(exp_v[g]), 32'(e.expd));
          chk("onehot0", g, 32'($onehot0(gnt_v[g])), 32'(1));
          chk("busy_or", g, 32'(busy_v[g]), 32'(|gnt_v[g]));
          chk("id_match", g, gnt_v[g], busy_v[g] ? 32'(1) << id_v[g] : '0);
          chk("gnt_no_req", g, gnt_v[g] & ~lg[g] & ~e.req, '0);
          for (int i = 0; i < NS[g]; i++) if (!e.mask[i]) wt[g][i] = 0;
          if (RRS[g] != 0 && lg[g] == '0 && gnt_v[g] != '0) begin
            mx = 0;
            for (int i = 0; i < NS[g]; i++) begin
              if (i == int'(id_v[g])) wt[g][i] = 0;
              else if (e.mask[i]) begin
                wt[g][i]++;
                if (wt[g][i] > mx) mx = wt[g][i];
              end
            end
            chk("rr_fair", g, 32'(mx <= NS[g] - 1), 32'(1));
          end
          lg[g] = gnt_v[g];
        end
      end
    end
  end
  initial begin
    logic [31:0] r;
    rst_n = 1'b1;
    for (int g = 0; g < NI; g++) req_v[g] = '0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    set_all(32'hE, 4);
    set_all(32'hC, 4);
    set_all(32'h0, 2);
    for (int c = 0; c < 16; c++) begin
      for (int g = 0; g < NI; g++) begin
        r = nmask(g);
        if (ms[g].owner >= 0 && ms[g].held >= 2) r[ms[g].owner] = 1'b0;
        req_v[g] = r;
      end
      tick();
    end
    set_all(32'h0, 2);
    set_all(32'h4, 8);
    set_all(32'h0, 1);
    set_all(32'h4, 5);
    set_all(32'h0, 2);
    for (int c = 0; c < 10; c++) begin
      for (int g = 0; g < NI; g++) begin
        r = 32'h4 & nmask(g);
        if (ms[g].owner == 2 && ms[g].held == 3) r = '0;
        req_v[g] = r;
      end
      tick();
    end
    set_all(32'h8, 3);
    do_reset();
    set_all(32'hF, 3);
    for (int c = 0; c < 10000; c++) begin
      if (c == 5000) do_reset();
      for (int g = 0; g < NI; g++)
        req_v[g] = (req_v[g] ^ ($urandom & $urandom & $urandom)) & nmask(g);
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
